// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per clock,
// start/busy/done handshake, sticky overflow when the value needs more digits.
module bin2bcd_seq #(
   parameter int W      = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [W-1:0]          bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] LAST_SHIFT = CW'(W - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    bin_q, bin_d;
   logic [BW-1:0]   bcd_q, bcd_d;
   logic            ovf_q, ovf_d;
   logic            done_q, done_d;
   logic [BW-1:0]   out_q, out_d;
   logic            out_ovf_q, out_ovf_d;

   logic [BW-1:0]   corrected;
   logic [BW-1:0]   shifted;
   logic            carry_out;

   // Every digit is corrected independently; a digit >= 5 would become >= 10
   // after doubling, so adding 3 first makes the doubling carry into the next digit.
   function automatic logic [BW-1:0] add3_all(input logic [BW-1:0] v);
      logic [BW-1:0] r;
      r = v;
      for (int k = 0; k < DIGITS; k++) begin
         if (v[4*k +: 4] >= 4'd5) begin
            r[4*k +: 4] = v[4*k +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   assign corrected = add3_all(bcd_q);
   assign shifted   = {corrected[BW-2:0], bin_q[W-1]};
   // The bit leaving the top digit is a carry worth 10^DIGITS: the value no longer fits.
   assign carry_out = corrected[BW-1];

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case leaves
      // it unassigned; otherwise synthesis infers a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      bin_d     = bin_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      out_d     = out_q;
      out_ovf_d = out_ovf_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               bin_d   = bin_in;
               bcd_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            bcd_d = shifted;
            bin_d = bin_q << 1;
            ovf_d = ovf_q | carry_out;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_SHIFT) begin
               out_d     = shifted;
               out_ovf_d = ovf_q | carry_out;
               done_d    = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the working registers are plain flops (not a memory array), so all of
   // them take the asynchronous reset and an aborted conversion leaves no residue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bin_q     <= '0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
         out_q     <= '0;
         out_ovf_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the values
         // from before this edge, independent of statement order.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
         out_q     <= out_d;
         out_ovf_q <= out_ovf_d;
      end
   end

   // All outputs come straight from flops: no input-to-output combinational path.
   assign busy     = (state_q == SHIFT);
   assign done     = done_q;
   assign bcd_out  = out_q;
   assign overflow = out_ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: four instances with different W/DIGITS,
// each scenario in its own task with inline comparisons.
module tb_bin2bcd_seq;

   logic clk;
   logic rst_n;

   // W=8, DIGITS=3
   logic        a_start, a_busy, a_done, a_ovf;
   logic [7:0]  a_bin;
   logic [11:0] a_bcd;
   // W=8, DIGITS=2
   logic        b_start, b_busy, b_done, b_ovf;
   logic [7:0]  b_bin;
   logic [7:0]  b_bcd;
   // W=16, DIGITS=5
   logic        c_start, c_busy, c_done, c_ovf;
   logic [15:0] c_bin;
   logic [19:0] c_bcd;
   // W=12, DIGITS=4
   logic        d_start, d_busy, d_done, d_ovf;
   logic [11:0] d_bin;
   logic [15:0] d_bcd;

   int total;
   int bad;

   bin2bcd_seq #(.W(8), .DIGITS(3)) u_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .bin_in(a_bin),
      .busy(a_busy), .done(a_done), .bcd_out(a_bcd), .overflow(a_ovf));
   bin2bcd_seq #(.W(8), .DIGITS(2)) u_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .bin_in(b_bin),
      .busy(b_busy), .done(b_done), .bcd_out(b_bcd), .overflow(b_ovf));
   bin2bcd_seq #(.W(16), .DIGITS(5)) u_c (
      .clk(clk), .rst_n(rst_n), .start(c_start), .bin_in(c_bin),
      .busy(c_busy), .done(c_done), .bcd_out(c_bcd), .overflow(c_ovf));
   bin2bcd_seq #(.W(12), .DIGITS(4)) u_d (
      .clk(clk), .rst_n(rst_n), .start(d_start), .bin_in(d_bin),
      .busy(d_busy), .done(d_done), .bcd_out(d_bcd), .overflow(d_ovf));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] ref_bcd4(input int v);
      logic [15:0] r;
      int x;
      r = '0;
      x = v;
      for (int k = 0; k < 4; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      total++;
      if ({a_busy, a_done, a_ovf, b_busy, b_done, b_ovf, c_busy, c_done, c_ovf,
           d_busy, d_done, d_ovf} !== 12'b0) begin
         bad++;
         $display("FAIL reset_flags: got %b want 0", {a_busy, a_done, a_ovf, b_busy,
                  b_done, b_ovf, c_busy, c_done, c_ovf, d_busy, d_done, d_ovf});
      end
      total++;
      if ({a_bcd, b_bcd, c_bcd, d_bcd} !== 56'h0) begin
         bad++;
         $display("FAIL reset_bcd: got %h want 0", {a_bcd, b_bcd, c_bcd, d_bcd});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({a_busy, a_done, c_busy, c_done} !== 4'b0) begin
         bad++;
         $display("FAIL idle_after_reset: got %b want 0000", {a_busy, a_done, c_busy, c_done});
      end
   endtask

   task automatic test_single_255();
      int n;
      int busy_cycles;
      a_bin = 8'd255; a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0; a_bin = 8'd17;   // must not disturb the conversion in flight
      n = 0; busy_cycles = 0;
      while (a_done !== 1'b1 && n < 50) begin
         if (a_busy === 1'b1) busy_cycles++;
         @(posedge clk); #1; n++;
      end
      total++;
      if (n != 8) begin
         bad++;
         $display("FAIL latency_255: got %0d cycles want 8", n);
      end
      total++;
      if (busy_cycles != 8) begin
         bad++;
         $display("FAIL busy_len_255: got %0d want 8", busy_cycles);
      end
      total++;
      if (a_bcd !== 12'h255 || a_ovf !== 1'b0 || a_busy !== 1'b0) begin
         bad++;
         $display("FAIL result_255: got bcd=%h ovf=%b busy=%b want 255/0/0", a_bcd, a_ovf, a_busy);
      end
      @(posedge clk); #1;
      total++;
      if (a_done !== 1'b0 || a_bcd !== 12'h255) begin
         bad++;
         $display("FAIL hold_255: got done=%b bcd=%h want 0/255", a_done, a_bcd);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      a_bin = 8'd0; a_start = 1'b1;
      @(posedge clk); #1;
      a_bin = 8'd9;                    // start stays high: ignored while busy
      n = 0;
      while (a_done !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      total++;
      if (n != 8 || a_bcd !== 12'h000 || a_ovf !== 1'b0) begin
         bad++;
         $display("FAIL b2b_first: got n=%0d bcd=%h ovf=%b want 8/000/0", n, a_bcd, a_ovf);
      end
      @(posedge clk); #1;
      a_start = 1'b0;
      n = 1;
      total++;
      if (a_busy !== 1'b1) begin
         bad++;
         $display("FAIL b2b_accept: got busy=%b want 1", a_busy);
      end
      while (a_done !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      total++;
      if (n != 9 || a_bcd !== 12'h009 || a_ovf !== 1'b0) begin
         bad++;
         $display("FAIL b2b_second: got n=%0d bcd=%h ovf=%b want 9/009/0", n, a_bcd, a_ovf);
      end
   endtask

   task automatic test_ignore_start();
      int n;
      int dones;
      int done_at;
      c_bin = 16'd65535; c_start = 1'b1;
      @(posedge clk); #1;
      c_start = 1'b0;
      dones = 0; done_at = -1;
      for (int i = 1; i <= 30; i++) begin
         if (i == 5) begin c_start = 1'b1; c_bin = 16'd1; end
         if (i == 6) c_start = 1'b0;
         @(posedge clk); #1;
         if (c_done === 1'b1) begin
            dones++;
            if (done_at < 0) done_at = i;
         end
      end
      total++;
      if (dones != 1 || done_at != 16) begin
         bad++;
         $display("FAIL ignore_start: got dones=%0d at=%0d want 1 at 16", dones, done_at);
      end
      total++;
      if (c_bcd !== 20'h65535 || c_ovf !== 1'b0) begin
         bad++;
         $display("FAIL result_65535: got bcd=%h ovf=%b want 65535/0", c_bcd, c_ovf);
      end
      n = 0;
   endtask

   task automatic test_overflow();
      int n;
      b_bin = 8'd123; b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      n = 0;
      while (b_done !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      total++;
      if (n != 8 || b_bcd !== 8'h23 || b_ovf !== 1'b1) begin
         bad++;
         $display("FAIL ovf_123: got n=%0d bcd=%h ovf=%b want 8/23/1", n, b_bcd, b_ovf);
      end
      b_bin = 8'd99; b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      @(posedge clk); #1;
      total++;
      if (b_busy !== 1'b1 || b_bcd !== 8'h23 || b_ovf !== 1'b1) begin
         bad++;
         $display("FAIL hold_during_busy: got busy=%b bcd=%h ovf=%b want 1/23/1", b_busy, b_bcd, b_ovf);
      end
      n = 1;
      while (b_done !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      total++;
      if (n != 8 || b_bcd !== 8'h99 || b_ovf !== 1'b0) begin
         bad++;
         $display("FAIL ovf_clear_99: got n=%0d bcd=%h ovf=%b want 8/99/0", n, b_bcd, b_ovf);
      end
   endtask

   task automatic test_abort();
      int n;
      int dones;
      c_bin = 16'd1234; c_start = 1'b1;
      @(posedge clk); #1;
      c_start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      total++;
      if (c_busy !== 1'b0 || c_done !== 1'b0 || c_bcd !== 20'h0 || c_ovf !== 1'b0) begin
         bad++;
         $display("FAIL abort_state: got busy=%b done=%b bcd=%h ovf=%b want 0/0/0/0",
                  c_busy, c_done, c_bcd, c_ovf);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (c_done === 1'b1 || c_busy === 1'b1) dones++;
      end
      total++;
      if (dones != 0 || c_bcd !== 20'h0) begin
         bad++;
         $display("FAIL abort_quiet: got activity=%0d bcd=%h want 0/0", dones, c_bcd);
      end
      c_bin = 16'd1234; c_start = 1'b1;
      @(posedge clk); #1;
      c_start = 1'b0;
      n = 0;
      while (c_done !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      total++;
      if (n != 16 || c_bcd !== 20'h01234 || c_ovf !== 1'b0) begin
         bad++;
         $display("FAIL after_abort_1234: got n=%0d bcd=%h ovf=%b want 16/01234/0", n, c_bcd, c_ovf);
      end
   endtask

   task automatic test_sweep();
      int v;
      int n;
      int errs_val;
      int errs_dig;
      logic [15:0] want;
      errs_val = 0; errs_dig = 0;
      for (int i = 0; i < 500; i++) begin
         case (i)
            0: v = 0;
            1: v = 4095;
            2: v = 999;
            3: v = 1000;
            default: v = int'($urandom_range(0, 4095));
         endcase
         want = ref_bcd4(v);
         d_bin = 12'(v); d_start = 1'b1;
         @(posedge clk); #1;
         d_start = 1'b0;
         n = 0;
         while (d_done !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
         end
         total++;
         if (n != 12 || d_bcd !== want || d_ovf !== 1'b0) begin
            bad++;
            errs_val++;
            if (errs_val <= 5)
               $display("FAIL sweep_%0d: got n=%0d bcd=%h ovf=%b want 12/%h/0", v, n, d_bcd, d_ovf, want);
         end
         total++;
         if (d_bcd[3:0] > 4'd9 || d_bcd[7:4] > 4'd9 || d_bcd[11:8] > 4'd9 || d_bcd[15:12] > 4'd9) begin
            bad++;
            errs_dig++;
            if (errs_dig <= 5)
               $display("FAIL sweep_digit_%0d: got bcd=%h want all digits <= 9", v, d_bcd);
         end
      end
   endtask

   initial begin
      total = 0; bad = 0;
      a_start = 1'b0; a_bin = '0;
      b_start = 1'b0; b_bin = '0;
      c_start = 1'b0; c_bin = '0;
      d_start = 1'b0; d_bin = '0;
      test_reset();
      test_single_255();
      test_back_to_back();
      test_ignore_start();
      test_overflow();
      test_abort();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
